// File: rtl/sram_pkg.sv
// sram_pkg: shared defaults and the reader state encoding used by sram_reader
// and its buffer sub-module.
package sram_pkg;

  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sram_reader_fifo.sv
// sram_reader_fifo: two-entry first-word-fall-through buffer between the SRAM
// read port and the streaming output.
//
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   i_push        write i_push_data (dropped if full)
//   i_push_data   word to store
//   i_pop         discard the head entry (ignored if empty)
//   o_head        head entry; storage resets to 0 so the head reads 0 after reset
//   o_count       occupancy 0..2
//   o_full        occupancy == 2
//   o_empty       occupancy == 0
module sram_reader_fifo
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_idx;
  logic              r_rd_idx;
  logic [1:0]        r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_push_ok = i_push && (r_count != 2'd2);
  assign w_pop_ok  = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_idx] <= i_push_data;
        r_wr_idx        <= ~r_wr_idx;
      end
      if (w_pop_ok) begin
        r_rd_idx <= ~r_rd_idx;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_idx];
  assign o_count = r_count;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/sram_reader.sv
// sram_reader: streams an inclusive SRAM address range (wrapping through 0)
// out over a valid/ready interface, keeping at most two words outstanding.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   start                     one-cycle request, accepted only in IDLE
//   base_addr, last_addr      inclusive range, sampled on accepted start
//   sram_cen, sram_wen        active-low SRAM controls (wen tied high)
//   sram_addr, sram_dout      SRAM address / read data (1-cycle latency)
//   dout, dout_valid          streamed word from the buffer head
//   dout_ready                sink handshake
//   busy, done                readout in progress / one-cycle completion pulse
//   mismatch_cnt              down-count checker errors (0 unless enabled)
//
// Build option: define SRAM_READER_CHECK_EN to add the down-count checker.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing reads while the buffer has room
// DRAIN | last read issued, emptying buffer and in-flight read
// DONE  | one-cycle done pulse
module sram_reader
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dout,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        mismatch_cnt
);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_end;
  logic              r_inflight;
  logic              w_issue;
  logic              w_pop;
  logic              w_start_acc;
  logic [2:0]        w_occ;
  logic [1:0]        w_count;
  logic              w_full;
  logic              w_empty;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_pop       = !w_empty && dout_ready;

  // Occupancy once this cycle's pop and the pending capture settle. Counting
  // the same-cycle pop is what sustains one word per cycle with two entries.
  assign w_occ = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        if (!w_full && (w_occ < 3'd2)) begin
          w_issue = 1'b1;
          if (r_rd_ptr == r_end) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_occ == 3'd0) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_rd_ptr   <= '0;
      r_end      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_start_acc) begin
        r_rd_ptr <= base_addr;
        r_end    <= last_addr;
      end else if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
    end
  end

  sram_reader_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (r_inflight),
    .i_push_data(sram_dout),
    .i_pop      (w_pop),
    .o_head     (dout),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign sram_cen   = ~w_issue;
  assign sram_wen   = 1'b1;
  assign sram_addr  = r_rd_ptr;
  assign dout_valid = !w_empty;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);

`ifdef SRAM_READER_CHECK_EN
  logic [7:0]        r_mis_cnt;
  logic [DATA_W-1:0] r_expect;
  logic              r_first;

  // Each word is expected to be one less than the word before it; the first
  // word of a readout only seeds the expectation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mis_cnt <= 8'd0;
      r_expect  <= '0;
      r_first   <= 1'b1;
    end else if (w_start_acc) begin
      r_mis_cnt <= 8'd0;
      r_first   <= 1'b1;
    end else if (w_pop) begin
      r_first  <= 1'b0;
      r_expect <= dout - DATA_W'(1);
      if (!r_first && (dout != r_expect) && (r_mis_cnt != 8'hFF)) begin
        r_mis_cnt <= r_mis_cnt + 8'd1;
      end
    end
  end

  assign mismatch_cnt = r_mis_cnt;
`else
  assign mismatch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sram_reader.sv
// tb_sram_reader: directed bench for sram_reader with a queue-based model of
// the expected address/word stream and a per-cycle compare on the falling edge.
module tb_sram_reader;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] last_addr;
  logic       sram_cen;
  logic       sram_wen;
  logic [7:0] sram_addr;
  logic [7:0] sram_dout;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       done;
  logic [7:0] mismatch_cnt;

  sram_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .base_addr   (base_addr),
    .last_addr   (last_addr),
    .sram_cen    (sram_cen),
    .sram_wen    (sram_wen),
    .sram_addr   (sram_addr),
    .sram_dout   (sram_dout),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .busy        (busy),
    .done        (done),
    .mismatch_cnt(mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM with one cycle of read latency
  logic [7:0] mem [256];
  always @(posedge clk) if (!sram_cen) sram_dout <= mem[sram_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // model state
  logic [7:0] exp_a[$];
  logic [7:0] exp_d[$];
  logic [7:0] got[$];
  bit         m_busy;
  bit         m_done_nxt;
  int         n_iss, iss_prev, n_xfer;
  bit         p_stall;
  logic [7:0] p_dout;

  task automatic mon_step();
    bit         busy_now;
    int         occ;
    logic [7:0] a;
    if (!rstn) begin
      exp_a.delete(); exp_d.delete();
      m_busy = 0; m_done_nxt = 0;
      n_iss = 0; iss_prev = 0; n_xfer = 0;
      p_stall = 0;
      return;
    end
    chk("wen", sram_wen, 1);
    chk("busy", busy, m_busy);
    chk("done", done, m_done_nxt);
    busy_now = m_busy;
    if (m_done_nxt) m_busy = 0;
    m_done_nxt = 0;
    if (p_stall) begin
      chk("hold_valid", dout_valid, 1);
      chk("hold_data", dout, p_dout);
    end
    // words captured (issued two or more cycles ago) but not yet transferred
    occ = iss_prev - n_xfer;
    if (occ >= 2) chk("cen_when_full", sram_cen, 1);
    iss_prev = n_iss;
    if (!sram_cen) begin
      if (exp_a.size() == 0) chk("stray_read", sram_cen, 1);
      else chk("addr", sram_addr, exp_a.pop_front());
      n_iss++;
    end
    if (dout_valid && dout_ready) begin
      if (exp_d.size() == 0) chk("stray_word", dout_valid, 0);
      else begin
        chk("data", dout, exp_d.pop_front());
        got.push_back(dout);
        if (exp_d.size() == 0) m_done_nxt = 1;
      end
      n_xfer++;
    end
    p_stall = dout_valid && !dout_ready;
    p_dout  = dout;
    if (start && !busy_now) begin
      got.delete();
      a = base_addr;
      for (int k = 0; k < 256; k++) begin
        exp_a.push_back(a);
        exp_d.push_back(mem[a]);
        if (a == last_addr) break;
        a = a + 8'd1;
      end
      m_busy = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cen"}, sram_cen, 1);
    chk({tag, "_wen"}, sram_wen, 1);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_miscnt"}, mismatch_cnt, 0);
  endtask

  // Start is held during cycle 0 and sampled at the end of it; cyc returns
  // the cycle number in which done is high.
  task automatic run(input logic [7:0] b, input logic [7:0] l, input bit rnd,
                     input bit poke, output int cyc, output int first_v, output int ncen);
    cyc = 0; first_v = -1; ncen = 0;
    base_addr = b; last_addr = l; start = 1'b1;
    dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (poke) begin
        start = (cyc == 3);
        if (cyc == 3) base_addr = 8'h55;
      end
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (done) break;
      if (!sram_cen) ncen++;
      if (dout_valid && first_v < 0) first_v = cyc;
      tick();
      cyc++;
    end
    chk("run_done", done, 1);
    if (poke) begin
      start = 1'b1;
      base_addr = 8'h30;
      last_addr = 8'h31;
    end
    tick();
    start = 1'b0;
    dout_ready = 1'b1;
  endtask

  int cyc, fv, nc;

  initial begin
    rstn = 1'b0; start = 1'b0; base_addr = 8'h00; last_addr = 8'h00; dout_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF - 8'(i);
    mem[8'h20] = 8'h50; mem[8'h21] = 8'h4F; mem[8'h22] = 8'h4D; mem[8'h23] = 8'h4C;

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    tick(); tick();
    chk_reset_outputs("por");
    rstn = 1'b1;
    tick();

    // 8 words at full rate: issues in cycles 1..8, valid 3..10, done in 11
    run(8'h00, 8'h07, 0, 0, cyc, fv, nc);
    chk("t1_done_cycle", cyc, 11);
    chk("t1_first_valid", fv, 3);
    chk("t1_reads", nc, 8);
    chk("t1_words", got.size(), 8);
    chk("t1_first_word", got[0], 8'hFF);
    chk("t1_last_word", got[7], 8'hF8);
    chk("t1_miscnt", mismatch_cnt, 0);

    // wrap through 0, with start pulses while busy and on done
    run(8'hFE, 8'h01, 0, 1, cyc, fv, nc);
    chk("t2_done_cycle", cyc, 7);
    chk("t2_reads", nc, 4);
    chk("t2_words", got.size(), 4);
    chk("t2_first_word", got[0], 8'h01);
    chk("t2_last_word", got[3], 8'hFE);
    chk("t2_idle_busy", busy, 0);

    // single word
    run(8'h10, 8'h10, 0, 0, cyc, fv, nc);
    chk("t3_done_cycle", cyc, 4);
    chk("t3_reads", nc, 1);
    chk("t3_words", got.size(), 1);
    chk("t3_word", got[0], 8'hEF);

    // 64 words under random backpressure
    run(8'h40, 8'h7F, 1, 0, cyc, fv, nc);
    chk("t4_reads", nc, 64);
    chk("t4_words", got.size(), 64);
    chk("t4_first_word", got[0], 8'hBF);
    chk("t4_last_word", got[63], 8'h80);
    chk("t4_miscnt", mismatch_cnt, 0);

    // reset in the middle of a readout, then a fresh readout
    base_addr = 8'h40; last_addr = 8'h7F; dout_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rstn = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    tick();
    rstn = 1'b1;
    tick();
    run(8'h00, 8'h03, 0, 0, cyc, fv, nc);
    chk("t5_done_cycle", cyc, 7);
    chk("t5_words", got.size(), 4);
    chk("t5_first_word", got[0], 8'hFF);
    chk("t5_last_word", got[3], 8'hFC);

    // 0x50, 0x4F, 0x4D, 0x4C: one break in the down-count
    run(8'h20, 8'h23, 0, 0, cyc, fv, nc);
    chk("t6_word2", got[2], 8'h4D);
`ifdef SRAM_READER_CHECK_EN
    chk("t6_miscnt", mismatch_cnt, 1);
`else
    chk("t6_miscnt", mismatch_cnt, 0);
`endif

    // a new readout clears the count
    run(8'h00, 8'h01, 0, 0, cyc, fv, nc);
    chk("t7_words", got.size(), 2);
    chk("t7_miscnt", mismatch_cnt, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
